// File: rtl/stepper_pkg.sv
// Shared types and phase patterns for the three-phase half-step sequencer.
package stepper_pkg;

    localparam logic [2:0] PH_A  = 3'b100;
    localparam logic [2:0] PH_AB = 3'b110;
    localparam logic [2:0] PH_B  = 3'b010;
    localparam logic [2:0] PH_BC = 3'b011;
    localparam logic [2:0] PH_C  = 3'b001;
    localparam logic [2:0] PH_CA = 3'b101;

    // 3-bit phase index; codes 6 and 7 are illegal and recover to PI_0
    typedef enum logic [2:0] {
        PI_0 = 3'd0,
        PI_1 = 3'd1,
        PI_2 = 3'd2,
        PI_3 = 3'd3,
        PI_4 = 3'd4,
        PI_5 = 3'd5
    } phase_t;

    function automatic logic [2:0] phase_decode(input phase_t p);
        logic [2:0] pat;
        case (p)
            PI_0:    pat = PH_A;
            PI_1:    pat = PH_AB;
            PI_2:    pat = PH_B;
            PI_3:    pat = PH_BC;
            PI_4:    pat = PH_C;
            PI_5:    pat = PH_CA;
            default: pat = PH_A;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/step_tick.sv
// STEP_DIV prescaler: one-cycle tick every STEP_DIV cycles, cleared by CR.
module step_tick #(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic CP,
    input  logic CR,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(STEP_DIV - 1);

    logic [15:0] cnt;

    // With STEP_DIV=1 the counter stays at 0 and tick is permanently high
    assign tick = (cnt == LAST);

    always_ff @(posedge CP) begin
        if (CR)
            cnt <= '0;
        else if (tick)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

endmodule

// File: rtl/stepper_ctrl.sv
// Three-phase six-beat stepper phase sequencer with registered coil enables.
// Optional macro STEPPER_SYNC_EN adds a 2-flop synchronizer on Sin.
module stepper_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned STEP_DIV = 1
) (
    input  logic       CP,
    input  logic       CR,
    input  logic       Sin,
    output logic [2:0] Out
);

    phase_t     p;
    phase_t     p_next;
    logic [2:0] out_next;
    logic       sin_s;
    logic       tick;

    step_tick #(.STEP_DIV(STEP_DIV)) u_tick (
        .CP   (CP),
        .CR   (CR),
        .tick (tick)
    );

`ifdef STEPPER_SYNC_EN
    logic [1:0] sync;

    always_ff @(posedge CP) begin
        if (CR)
            sync <= '1;
        else
            sync <= {sync[0], Sin};
    end

    assign sin_s = sync[1];
`else
    assign sin_s = Sin;
`endif

    always_comb begin
        p_next = p;
        case (p)
            PI_0:    if (tick) p_next = sin_s ? PI_1 : PI_5;
            PI_1:    if (tick) p_next = sin_s ? PI_2 : PI_0;
            PI_2:    if (tick) p_next = sin_s ? PI_3 : PI_1;
            PI_3:    if (tick) p_next = sin_s ? PI_4 : PI_2;
            PI_4:    if (tick) p_next = sin_s ? PI_5 : PI_3;
            PI_5:    if (tick) p_next = sin_s ? PI_0 : PI_4;
            default: p_next = PI_0;
        endcase
        // Out is decoded from the next index so it changes on the tick edge itself
        out_next = phase_decode(p_next);
    end

    always_ff @(posedge CP) begin
        if (CR) begin
            p   <= PI_0;
            Out <= PH_A;
        end else begin
            p   <= p_next;
            Out <= out_next;
        end
    end

endmodule

// File: tb/tb_stepper_ctrl.sv
// Randomized self-checking bench for stepper_ctrl at STEP_DIV=1 and STEP_DIV=3.
module tb_stepper_ctrl;

    logic       cp  = 1'b0;
    logic       cr  = 1'b1;
    logic       sin = 1'b0;
    logic [2:0] out1;
    logic [2:0] out3;

    always #5 cp = ~cp;

    stepper_ctrl #(.STEP_DIV(1)) dut1 (
        .CP  (cp),
        .CR  (cr),
        .Sin (sin),
        .Out (out1)
    );

    stepper_ctrl #(.STEP_DIV(3)) dut3 (
        .CP  (cp),
        .CR  (cr),
        .Sin (sin),
        .Out (out3)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] pats [6] = '{3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101};

    // Reference: phase as a plain integer 0..5, edges counted since the last reset
    int p1 = 0;
    int p3 = 0;
    int k  = 0;
    bit q[$];

    task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle();
        bit d;
        if (cr) begin
            p1 = 0;
            p3 = 0;
            k  = 0;
            q.delete();
        end else begin
            k++;
            q.push_back(sin);
`ifdef STEPPER_SYNC_EN
            d = (q.size() >= 3) ? q[q.size() - 3] : 1'b1;
`else
            d = sin;
`endif
            p1 = d ? (p1 + 1) % 6 : (p1 + 5) % 6;
            if (k % 3 == 0)
                p3 = d ? (p3 + 1) % 6 : (p3 + 5) % 6;
        end
        @(posedge cp);
        #1;
        check("seq_div1", out1, pats[p1]);
        check("seq_div3", out3, pats[p3]);
        check("legal_div1", (out1 == 3'b000 || out1 == 3'b111) ? 3'd1 : 3'd0, 3'd0);
        check("legal_div3", (out3 == 3'b000 || out3 == 3'b111) ? 3'd1 : 3'd0, 3'd0);
    endtask

    initial begin
        int guard;

        cr  = 1'b1;
        sin = 1'b0;
        cycle();
        cycle();

        cr  = 1'b0;
        sin = 1'b1;
        repeat (14) cycle();

        sin = 1'b0;
        repeat (14) cycle();

        for (int r = 0; r < 4; r++) begin
            sin = ~sin;
            repeat (12) cycle();
        end

        sin   = 1'b1;
        guard = 0;
        while (out1 !== 3'b001 && guard < 12) begin
            cycle();
            guard++;
        end
        check("reach_001", out1, 3'b001);
        cr = 1'b1;
        cycle();
        cr = 1'b0;
        repeat (8) cycle();

        repeat (300) begin
            if ($urandom_range(0, 3) == 0)
                sin = ~sin;
            cr = ($urandom_range(0, 39) == 0);
            cycle();
        end
        cr = 1'b0;
        repeat (6) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
